// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store path: funct3 codes, fault codes
// and the LSU state encoding.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_TIMEOUT  = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu32_if.sv
// Word-wide memory bus between the LSU (master) and memory (slave).
interface lsu32_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load extraction with
// sign/zero extension, and legality/alignment flags for a funct3.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wstrb      = 4'b0000;
    wdata_rep  = wdata;
    load_data  = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB: begin
        if (store) begin
          wstrb     = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end else begin
          load_data = {{24{lane_b[7]}}, lane_b};
        end
      end
      F3_LH: begin
        misaligned = addr_lo[0];
        if (store) begin
          wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end else begin
          load_data = {{16{lane_h[15]}}, lane_h};
        end
      end
      F3_LW: begin
        misaligned = (addr_lo != 2'b00);
        if (store) wstrb = 4'b1111;
        else       load_data = mem_rdata;
      end
      // Unsigned variants exist only for loads.
      F3_LBU: begin
        illegal   = store;
        load_data = {24'h0, lane_b};
      end
      F3_LHU: begin
        illegal    = store;
        misaligned = addr_lo[0];
        load_data  = {16'h0, lane_h};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu32.sv
// Load/store unit: request latch, IDLE/ACCESS/DONE sequencer and bus-wait
// timeout for one word-bus access per instruction.
//   state     | meaning
//   ST_IDLE   | waiting for req_valid; faults are detected here without bus activity
//   ST_ACCESS | mem_req held until mem_ready or the wait counter expires
//   ST_DONE   | one-cycle done pulse carrying rdata/fault
module lsu32
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  lsu32_if.master     bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state, state_n;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  fault_e      fault_q;
  logic [CW-1:0] cnt;

  logic        in_idle, in_access, timeout_hit;
  logic        a_store;
  logic [2:0]  a_funct3;
  logic [1:0]  a_addr_lo;
  logic [31:0] a_wdata;
  logic [3:0]  wstrb;
  logic [31:0] wdata_rep, load_data;
  logic        misaligned, illegal;

  assign in_idle   = (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Flags must be judged on the live request in IDLE; afterwards the latch drives the lanes.
  assign a_store   = in_idle ? req_store      : store_q;
  assign a_funct3  = in_idle ? req_funct3     : funct3_q;
  assign a_addr_lo = in_idle ? req_addr[1:0]  : addr_q[1:0];
  assign a_wdata   = in_idle ? req_wdata      : wdata_q;

  lsu_align u_align (
    .store      (a_store),
    .funct3     (a_funct3),
    .addr_lo    (a_addr_lo),
    .wdata      (a_wdata),
    .mem_rdata  (bus.mem_rdata),
    .wstrb      (wstrb),
    .wdata_rep  (wdata_rep),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_n = (illegal || misaligned) ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.mem_ready || timeout_hit) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= FLT_NONE;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'h0;
            cnt      <= '0;
            fault_q  <= illegal ? FLT_ILLEGAL : (misaligned ? FLT_MISALIGN : FLT_NONE);
          end
        end
        ST_ACCESS: begin
          if (bus.mem_ready) rdata_q <= store_q ? 32'h0 : load_data;
          else if (timeout_hit) fault_q <= FLT_TIMEOUT;
          else cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy  = !in_idle;
  assign done  = (state == ST_DONE);
  assign rdata = done ? rdata_q : 32'h0;
  assign fault = done ? fault_q : FLT_NONE;

  assign bus.mem_req   = in_access;
  assign bus.mem_we    = in_access && store_q;
  assign bus.mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wstrb = in_access ? wstrb : 4'b0000;
  assign bus.mem_wdata = (in_access && store_q) ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_lsu32.sv
// Scoreboard bench for lsu32: directed scenarios plus random loads/stores
// against a byte-level reference model, with a randomly stalling memory.
module tb_lsu32;
  import rv32i_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, done;
  logic [31:0] rdata;
  logic [1:0]  fault;

  lsu32_if bus ();

  lsu32 #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .fault      (fault),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          done_cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: ready after mem_wait stalled cycles; random ready/data when idle.
  int          mem_wait = 0;
  logic [31:0] mem_word = 32'h0;
  int          wc = 0;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wc == mem_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_word;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      wc++;
    end else begin
      wc = 0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (!rst && done) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = resp_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("fault", 32'(fault), 32'(e.fault));
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Bus monitor: every mem_req cycle checked against the expected transaction
  bus_t cur;
  logic active = 1'b0, have_cur = 1'b0;
  int   req_len = 0;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (!active) begin
        active  = 1'b1;
        req_len = 0;
        if (bus_q.size() == 0) begin
          have_cur = 1'b0;
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: got mem_req=1 expected 0 (cycle %0d)", cyc);
        end else begin
          have_cur = 1'b1;
          cur = bus_q.pop_front();
        end
      end
      req_len++;
      if (have_cur) begin
        check("mem_we", 32'(bus.mem_we), 32'(cur.we));
        check("mem_addr", bus.mem_addr, cur.addr);
        check("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur.strb));
        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
      end
    end else if (active) begin
      active = 1'b0;
      if (have_cur) check("mem_req_len", 32'(req_len), 32'(cur.len));
    end
  end

  // Reference model + driver for one request
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int w);
    resp_t r;
    bus_t  b;
    int    sz, off, lat;
    logic  ill, mis, got;
    logic [31:0] val, mask;

    ill = st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = 1 << f3[1:0];
    off = int'(a % 4);
    mis = (a % sz) != 0;
    r.rdata = 32'h0;
    if (ill)      r.fault = 2'b11;
    else if (mis) r.fault = 2'b01;
    else          r.fault = 2'b00;

    if (r.fault != 2'b00) lat = 1;
    else if (w >= T) begin lat = T + 1; r.fault = 2'b10; end
    else lat = w + 2;

    if (r.fault == 2'b00 && !st) begin
      val = rd >> (8 * off);
      if (sz < 4) begin
        mask = (32'h1 << (8 * sz)) - 32'h1;
        val  = val & mask;
        if (!f3[2] && val[8*sz-1]) val = val | ~mask;
      end
      r.rdata = val;
    end

    b.we = st;
    b.addr = a & ~32'h3;
    b.strb = 4'b0000;
    b.wdata = 32'h0;
    b.len = (w >= T) ? T : w + 1;
    if (st) begin
      for (int i = 0; i < 4; i++) begin
        b.strb[i] = (i >= off) && (i < off + sz);
        b.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
      end
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    mem_wait = w;
    mem_word = rd;
    r.done_cyc = cyc + lat;
    resp_q.push_back(r);
    if (!ill && !mis) bus_q.push_back(b);

    // The core holds its request until done; held req_valid must be ignored while busy.
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles (addr %h)", a);
      resp_q.delete();
      bus_q.delete();
    end
  endtask

  task automatic reset_mid_access();
    bus_t b;
    b.we = 1'b0;
    b.addr = 32'h5000;
    b.strb = 4'b0000;
    b.wdata = 32'h0;
    b.len = 2;
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b0;
    req_funct3 = F3_LW;
    req_addr = 32'h5000;
    mem_wait = 10;
    bus_q.push_back(b);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    check("reset_mem_req", 32'(bus.mem_req), 32'h0);
    check("reset_mem_we", 32'(bus.mem_we), 32'h0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check("reset_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("reset_mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    run_req(1'b0, F3_LB,  32'h1003, 32'h0,         32'h80FF_1234, 0);
    run_req(1'b0, F3_LHU, 32'h2002, 32'h0,         32'hBEEF_0000, 3);
    run_req(1'b1, F3_SB,  32'h3001, 32'h0000_00AB, 32'h0,         1);
    run_req(1'b1, F3_SH,  32'h3002, 32'h1234_5678, 32'h0,         0);
    run_req(1'b0, F3_LW,  32'h4002, 32'h0,         32'h0,         0);
    run_req(1'b0, 3'b011, 32'h4000, 32'h0,         32'h0,         0);
    run_req(1'b1, 3'b101, 32'h4001, 32'h0,         32'h0,         0);
    run_req(1'b0, F3_LW,  32'h6000, 32'h0,         32'h1111_2222, T + 2);
    run_req(1'b0, F3_LH,  32'h6006, 32'h0,         32'h8001_7FFF, T - 1);
    reset_mid_access();
    run_req(1'b1, F3_SW,  32'h7000, 32'hCAFE_F00D, 32'h0,         1);

    for (int n = 0; n < 300; n++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, $urandom_range(0, T + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (resp_q.size() != 0 || bus_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0",
               resp_q.size(), bus_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
